// File: rtl/global_ram_responder.sv
// global_ram_responder: byte-wide RAM serving word/bit read/write requests through a four-state FSM
module global_ram_responder #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] GloablRAM_Addr_Input,
  input  logic        GloablRAM_Word_WriteRequest,
  input  logic [7:0]  GloablRAM_Word_WriteData,
  input  logic        GloablRAM_Word_ReadRequest,
  output logic [7:0]  GloablRAM_Word_ReadData,
  input  logic        GloablRAM_Bit_WriteRequest,
  input  logic        GloablRAM_Bit_WriteData,
  input  logic        GloablRAM_Bit_ReadRequest,
  output logic        GloablRAM_Bit_ReadData,
  output logic        GloablRAM_Word_WriteReadyStatus,
  output logic        GloablRAM_Word_ReadReadyStatus,
  output logic        GloablRAM_Bit_WriteReadyStatus,
  output logic        GloablRAM_Bit_ReadReadyStatus,
  output logic        GloablRAM_Busy
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  typedef enum logic [1:0] {WW, BW, WR, BR} kind_t;
  state_t state_q, state_d;
  kind_t kind_q, kind_d;
  logic [DEPTH_LOG2-1:0] byte_q, byte_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] wdata_q, wdata_d, rreg_q, rreg_d, word_rd_q, word_rd_d, merged;
  logic bdata_q, bdata_d, bit_rd_q, bit_rd_d, any_req, addr_unused;
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  assign any_req = GloablRAM_Word_WriteRequest | GloablRAM_Bit_WriteRequest |
                   GloablRAM_Word_ReadRequest | GloablRAM_Bit_ReadRequest;
  assign addr_unused = ^GloablRAM_Addr_Input;
  assign GloablRAM_Word_ReadData = word_rd_q;
  assign GloablRAM_Bit_ReadData = bit_rd_q;
  assign GloablRAM_Word_WriteReadyStatus = state_q == DONE && kind_q == WW;
  assign GloablRAM_Bit_WriteReadyStatus = state_q == DONE && kind_q == BW;
  assign GloablRAM_Word_ReadReadyStatus = state_q == DONE && kind_q == WR;
  assign GloablRAM_Bit_ReadReadyStatus = state_q == DONE && kind_q == BR;
  assign GloablRAM_Busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    kind_d = kind_q;
    byte_d = byte_q;
    bit_d = bit_q;
    wdata_d = wdata_q;
    bdata_d = bdata_q;
    rreg_d = rreg_q;
    word_rd_d = word_rd_q;
    bit_rd_d = bit_rd_q;
    mem_d = mem_q;
    merged = rreg_q;
    merged[bit_q] = bdata_q;
    if (state_q == IDLE && any_req) begin
      state_d = ACCESS;
      kind_d = GloablRAM_Word_WriteRequest ? WW :
               GloablRAM_Bit_WriteRequest  ? BW :
               GloablRAM_Word_ReadRequest  ? WR : BR;
      byte_d = (kind_d == WW || kind_d == WR) ? GloablRAM_Addr_Input[DEPTH_LOG2-1:0]
                                              : GloablRAM_Addr_Input[DEPTH_LOG2+2:3];
      bit_d = GloablRAM_Addr_Input[2:0];
      wdata_d = GloablRAM_Word_WriteData;
      bdata_d = GloablRAM_Bit_WriteData;
    end
    if (state_q == ACCESS) begin
      state_d = kind_q == WW ? DONE : WAIT;
      rreg_d = mem_q[byte_q];
      if (kind_q == WW) mem_d[byte_q] = wdata_q;
    end
    if (state_q == WAIT) begin
      state_d = DONE;
      word_rd_d = kind_q == WR ? rreg_q : word_rd_q;
      bit_rd_d = kind_q == BR ? rreg_q[bit_q] : bit_rd_q;
      if (kind_q == BW) mem_d[byte_q] = merged;
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kind_q <= WW;
      byte_q <= '0;
      bit_q <= '0;
      wdata_q <= '0;
      bdata_q <= 1'b0;
      rreg_q <= '0;
      word_rd_q <= '0;
      bit_rd_q <= 1'b0;
      mem_q <= '{default: 8'h00};
    end else begin
      state_q <= state_d;
      kind_q <= kind_d;
      byte_q <= byte_d;
      bit_q <= bit_d;
      wdata_q <= wdata_d;
      bdata_q <= bdata_d;
      rreg_q <= rreg_d;
      word_rd_q <= word_rd_d;
      bit_rd_q <= bit_rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: tb/tb_global_ram_responder.sv
// tb_global_ram_responder: randomized scoreboard bench for global_ram_responder
module tb_global_ram_responder;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] addr;
  logic ww, bw, wr, br, bwd, brd;
  logic [7:0] wwd, wrd;
  logic wwr, wrr, bwr, brr, busy;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int kind;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];
  logic [7:0] model [256];
  always #5 clk = ~clk;
  global_ram_responder dut (
    .clk(clk),
    .rst(rst),
    .GloablRAM_Addr_Input(addr),
    .GloablRAM_Word_WriteRequest(ww),
    .GloablRAM_Word_WriteData(wwd),
    .GloablRAM_Word_ReadRequest(wr),
    .GloablRAM_Word_ReadData(wrd),
    .GloablRAM_Bit_WriteRequest(bw),
    .GloablRAM_Bit_WriteData(bwd),
    .GloablRAM_Bit_ReadRequest(br),
    .GloablRAM_Bit_ReadData(brd),
    .GloablRAM_Word_WriteReadyStatus(wwr),
    .GloablRAM_Word_ReadReadyStatus(wrr),
    .GloablRAM_Bit_WriteReadyStatus(bwr),
    .GloablRAM_Bit_ReadReadyStatus(brr),
    .GloablRAM_Busy(busy)
  );
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model_push(int k, logic [15:0] a, logic [7:0] d, logic b);
    exp_t e;
    int wi;
    int bi;
    int bt;
    wi = int'(a) % 256;
    bi = (int'(a) / 8) % 256;
    bt = int'(a) % 8;
    e.kind = k;
    e.data = 8'h00;
    case (k)
      0: model[wi] = d;
      1: model[bi][bt] = b;
      2: e.data = model[wi];
      default: e.data = {7'd0, model[bi][bt]};
    endcase
    sb.push_back(e);
  endfunction
  task automatic set_req(int k, logic v);
    case (k)
      0: ww = v;
      1: bw = v;
      2: wr = v;
      default: br = v;
    endcase
  endtask
  function automatic logic ready_of(int k);
    return k == 0 ? wwr : k == 1 ? bwr : k == 2 ? wrr : brr;
  endfunction
  task automatic run(int k, logic [15:0] a, logic [7:0] d, logic b, bit drop_early);
    int cyc;
    cyc = 0;
    @(negedge clk);
    addr = a;
    wwd = d;
    bwd = b;
    set_req(k, 1'b1);
    model_push(k, a, d, b);
    do begin
      @(negedge clk);
      cyc++;
      if (drop_early && cyc == 1) set_req(k, 1'b0);
    end while (!ready_of(k) && cyc < 12);
    check("latency", cyc, k == 0 ? 2 : 3);
    set_req(k, 1'b0);
  endtask
  always @(negedge clk) begin : mon
    int k;
    exp_t e;
    if (wwr | bwr | wrr | brr) begin
      k = wwr ? 0 : bwr ? 1 : wrr ? 2 : 3;
      check("ready_onehot", 32'($onehot({wwr, bwr, wrr, brr})), 1);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: got kind %0d with no transaction outstanding", k);
      end else begin
        e = sb.pop_front();
        check("ready_kind", k, e.kind);
        if (k == 2) check("word_read_data", wrd, e.data);
        if (k == 3) check("bit_read_data", brd, e.data);
      end
    end
  end
  initial begin
    int k;
    int cyc;
    logic [15:0] a;
    rst = 1'b1;
    ww = 0; bw = 0; wr = 0; br = 0;
    addr = '0; wwd = '0; bwd = 0;
    foreach (model[i]) model[i] = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_ready", {wwr, bwr, wrr, brr}, 0);
    check("rst_word_rd", wrd, 0);
    check("rst_bit_rd", brd, 0);
    run(2, 16'h0005, 0, 0, 0);
    run(0, 16'h0012, 8'hA5, 0, 0);
    run(2, 16'h0012, 0, 0, 0);
    run(2, 16'h0112, 0, 0, 0);
    run(0, 16'h0002, 8'hA5, 0, 0);
    run(1, 16'h0011, 0, 1, 0);
    run(2, 16'h0002, 0, 0, 0);
    run(3, 16'h0011, 0, 0, 0);
    run(3, 16'h0010, 0, 0, 0);
    run(3, 16'h0016, 0, 0, 0);
    @(negedge clk);
    addr = 16'h0011;
    wwd = 8'h3C;
    bwd = 1'b0;
    ww = 1; bw = 1; wr = 1; br = 1;
    for (int i = 0; i < 4; i++) model_push(i, 16'h0011, 8'h3C, 1'b0);
    cyc = 0;
    while ((ww | bw | wr | br) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (wwr) ww = 0;
      if (bwr) bw = 0;
      if (wrr) wr = 0;
      if (brr) br = 0;
    end
    check("all4_drained", {ww, bw, wr, br}, 0);
    @(negedge clk);
    addr = 16'h0003;
    wwd = 8'hFF;
    ww = 1;
    @(negedge clk);
    check("access_busy", busy, 1);
    rst = 1'b1;
    ww = 0;
    @(negedge clk);
    rst = 1'b0;
    foreach (model[i]) model[i] = 8'h00;
    check("abort_busy", busy, 0);
    check("abort_ready", {wwr, bwr, wrr, brr}, 0);
    check("abort_word_rd", wrd, 0);
    check("abort_bit_rd", brd, 0);
    run(2, 16'h0003, 0, 0, 0);
    run(0, 16'h0012, 8'h5A, 0, 0);
    run(2, 16'h0012, 0, 0, 1);
    repeat (3) begin
      @(negedge clk);
      check("no_recapture", busy, 0);
    end
    repeat (80) begin
      k = int'($urandom_range(0, 3));
      a = 16'($urandom);
      if ($urandom_range(0, 1) == 1) a[10:4] = 7'd0;
      run(k, a, 8'($urandom), 1'($urandom), 0);
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/global_ram_responder.md
# global_ram_responder

Memory-side responder for the cache-to-global-RAM link. It services bit and word read and write requests from one CPU cache's global RAM port. It owns a byte-wide register-array memory, arbitrates simultaneous requests, and returns a one-cycle ready-status pulse per completed transaction. Bit writes are executed internally as read-modify-write.

## Interface
Parameters:
- DEPTH_LOG2, default 8: memory holds 2^DEPTH_LOG2 bytes.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- GloablRAM_Addr_Input  in  16  address. Word access uses byte = addr[DEPTH_LOG2-1:0]. Bit access uses byte = addr[DEPTH_LOG2+2:3] and bit = addr[2:0]. Higher bits are ignored, so addresses wrap.
- GloablRAM_Word_WriteRequest  in  1  word write request (level)
- GloablRAM_Word_WriteData  in  8  word write data
- GloablRAM_Word_ReadRequest  in  1  word read request (level)
- GloablRAM_Word_ReadData  out  8  word read result
- GloablRAM_Bit_WriteRequest  in  1  bit write request (level)
- GloablRAM_Bit_WriteData  in  1  bit write value
- GloablRAM_Bit_ReadRequest  in  1  bit read request (level)
- GloablRAM_Bit_ReadData  out  1  bit read result
- GloablRAM_Word_WriteReadyStatus  out  1  one-cycle completion pulse
- GloablRAM_Word_ReadReadyStatus  out  1  one-cycle completion pulse
- GloablRAM_Bit_WriteReadyStatus  out  1  one-cycle completion pulse
- GloablRAM_Bit_ReadReadyStatus  out  1  one-cycle completion pulse
- GloablRAM_Busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE: if any request is high, capture the address, write data and kind, then go to ACCESS.
  - Priority when several requests are high: word write > bit write > word read > bit read.
  - Losing requests are not captured. They are serviced later while still held.
- ACCESS:
  - Word write: write the byte, go to DONE.
  - Word read, bit read or bit write: latch the addressed byte into the internal read register, go to WAIT.
- WAIT:
  - Word read: ReadData <= byte.
  - Bit read: Bit_ReadData <= byte[bit].
  - Bit write: write back the byte with only [bit] replaced; the other 7 bits are unchanged.
  - Go to DONE.
- DONE: pulse the ReadyStatus matching the captured kind for exactly one cycle, then go to IDLE.
- Handshake:
  - The requester holds its request high until it sees the matching ReadyStatus.
  - The requester drops the request on the clock edge that ends DONE, so IDLE never re-captures the same transaction.
  - A request dropped early does not abort the transaction; the ready pulse still occurs.
- Read data outputs hold their value until the next completed read of the same kind.
- Writes and reads go only through captured registers; input changes after capture have no effect.

## Timing
- Reset (rst high at an edge) forces:
  - state = IDLE;
  - all ReadyStatus = 0, Busy = 0, Word_ReadData = 8'h00, Bit_ReadData = 0;
  - all memory bytes = 8'h00.
- Reset has priority in every state. Asserting it in ACCESS or WAIT aborts the transaction: no memory write is committed and no ready pulse is issued.
- Latency, counting the capture cycle (IDLE, request high) as cycle 0:
  - Word write: write committed at the end of cycle 1; ready high in cycle 2.
  - Reads and bit write: ready high in cycle 3. Read data is valid in cycle 3 and stays valid after.
- Throughput: the next capture is possible in the cycle after DONE. This gives a minimum period of 3 cycles for a word write and 4 cycles otherwise.
- Busy is high in ACCESS, WAIT and DONE.
- At most one ReadyStatus output is high in any cycle.
- Read after write to the same byte returns the new value; the write is committed before the next capture.

## Test plan
- Reset then word read at addr 16'h0005 -> Word_ReadReadyStatus pulses in cycle 3; ReadData = 8'h00.
- Word write 8'hA5 to addr 16'h0012, then word read of 16'h0012 -> write ready in cycle 2; read returns 8'hA5. Word read of 16'h0112 (aliases with DEPTH_LOG2=8) also returns 8'hA5.
- Byte 2 = 8'hA5, then bit write value 1 to bit addr 16'h0011 (byte 2, bit 1) -> byte becomes 8'hA7. Bit read of 16'h0011 returns 1; bit read of 16'h0010 returns 1; bit read of 16'h0016 returns 0.
- All four requests raised in the same cycle and held until each ready -> ready order is word write, bit write, word read, bit read. No cycle has two ReadyStatus high.
- Word write 8'hFF to 16'h0003, with rst asserted during ACCESS -> no ready pulse; byte 3 reads 8'h00 afterwards; all outputs are 0 in the cycle after reset.
- Word read request dropped in cycle 1 -> ready still pulses in cycle 3; the FSM returns to IDLE with no second capture.
